// File: rtl/quad_enc_decoder.sv
// Quadrature encoder receiver: 2-FF input sync, per-channel glitch filter,
// 4x gray decode into a wrapping signed position with direction, step and error reporting.
//
// state | meaning
// INIT  | settling after reset; on the 3rd edge filt is loaded straight from the synchronizers
// TRACK | filtering A/B and decoding each filtered transition
module quad_enc_decoder #(
    parameter int CNT_W    = 16,
    parameter int FILT_CYC = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] pos,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             err_flag
);

    localparam int FW = (FILT_CYC < 2) ? 1 : $clog2(FILT_CYC);
    localparam logic [FW-1:0] CNT_LAST = FW'(FILT_CYC - 1);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       init_cnt, init_nxt;
    logic [1:0]       sync_m, sync_s;
    logic [1:0]       filt, filt_nxt;
    logic [1:0]       filt_d, filt_d_nxt;
    logic [FW-1:0]    cnt_a, cnt_a_nxt;
    logic [FW-1:0]    cnt_b, cnt_b_nxt;
    logic [CNT_W-1:0] pos_nxt;
    logic             dir_nxt, step_nxt, err_nxt, flag_nxt;

    // Returns {accepted level, next counter} for one channel.
    function automatic logic [FW:0] filt_step(input logic s, input logic f,
                                              input logic [FW-1:0] c);
        logic [FW:0] r;
        r = {f, {FW{1'b0}}};
        if (s != f) begin
            if (c == CNT_LAST) r = {s, {FW{1'b0}}};
            else               r = {f, c + FW'(1)};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync_m <= '0;
            sync_s <= '0;
        end else begin
            sync_m <= {a, b};
            sync_s <= sync_m;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state    <= INIT;
            init_cnt <= '0;
            filt     <= '0;
            filt_d   <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            pos      <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_nxt;
            filt     <= filt_nxt;
            filt_d   <= filt_d_nxt;
            cnt_a    <= cnt_a_nxt;
            cnt_b    <= cnt_b_nxt;
            pos      <= pos_nxt;
            dir      <= dir_nxt;
            step     <= step_nxt;
            err      <= err_nxt;
            err_flag <= flag_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        init_nxt   = init_cnt;
        filt_nxt   = filt;
        filt_d_nxt = filt_d;
        cnt_a_nxt  = '0;
        cnt_b_nxt  = '0;
        pos_nxt    = pos;
        dir_nxt    = dir;
        step_nxt   = 1'b0;
        err_nxt    = 1'b0;
        flag_nxt   = err_flag;

        case (state)
            INIT: begin
                // Loading filt and its history together keeps a high A/B at release from counting.
                if (init_cnt == 2'd2) begin
                    filt_nxt   = sync_s;
                    filt_d_nxt = sync_s;
                    init_nxt   = '0;
                    state_nxt  = TRACK;
                end else begin
                    init_nxt = init_cnt + 2'd1;
                end
            end
            TRACK: begin
                {filt_nxt[1], cnt_a_nxt} = filt_step(sync_s[1], filt[1], cnt_a);
                {filt_nxt[0], cnt_b_nxt} = filt_step(sync_s[0], filt[0], cnt_b);
                filt_d_nxt = filt;
                case ({filt_d, filt})
                    4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
                        pos_nxt  = pos + CNT_W'(1);
                        dir_nxt  = 1'b1;
                        step_nxt = 1'b1;
                    end
                    4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                        pos_nxt  = pos - CNT_W'(1);
                        dir_nxt  = 1'b0;
                        step_nxt = 1'b1;
                    end
                    4'b0011, 4'b1100, 4'b1001, 4'b0110: begin
                        err_nxt  = 1'b1;
                        flag_nxt = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_nxt = INIT;
        endcase

        if (clr) begin
            pos_nxt  = '0;
            flag_nxt = 1'b0;
            step_nxt = 1'b0;
            err_nxt  = 1'b0;
        end
    end

endmodule
